// File: rtl/serial_adder_pkg.sv
// serial_adder shared types and constants.
// State encoding and counter-width helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } sa_state_t;

  localparam int DEF_WIDTH = 8;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  // Bit-counter width for a given operand width.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
// Purely combinational; shared by every bit position.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and carry of one bit slice.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor, LSB first.
// One full-adder cell plus carry FF, start/busy/done handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             ovf
);

  localparam int CW = cnt_width(WIDTH);

  sa_state_t        state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-2:0] r_q, r_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] s_q;
  logic             c_q, ovf_q;
  logic             sum, co;
  logic             accept, last;

  assign accept = start & ((state_q == IDLE) | (state_q == DONE));
  assign last   = (state_q == RUN) & (cnt_q == CW'(WIDTH - 1));

  full_adder u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (sum),
    .co (co)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result register shifted right, new sum bit entering at the top.
  always_comb begin
    r_d = r_q;
    r_d[WIDTH-2] = sum;
    for (int i = 0; i < WIDTH - 2; i++) begin
      r_d[i] = r_q[i+1];
    end
  end

  // Operand capture, serial datapath and result latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      c_q     <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub | cin;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      carry_q <= co;
      cnt_q   <= cnt_q + CW'(1);
      r_q     <= r_d;
      if (last) begin
        s_q   <= {sum, r_q};
        c_q   <= co;
        ovf_q <= carry_q ^ co;
      end
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign c    = c_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8).
// Scoreboard of expected results popped on done.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, c, ovf;
  logic [W-1:0] s;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         ovf;
    int           stamp;
  } exp_t;

  exp_t sb[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .c     (c),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic exp_t model(
    input logic [W-1:0] ia,
    input logic [W-1:0] ib,
    input logic         icin,
    input logic         isub
  );
    exp_t         e;
    logic [W-1:0] bb;
    logic [W:0]   t;
    bb = isub ? ~ib : ib;
    t = {1'b0, ia} + {1'b0, bb} + {{W{1'b0}}, (isub | icin)};
    e.s = t[W-1:0];
    e.c = t[W];
    e.ovf = (ia[W-1] == bb[W-1]) && (e.s[W-1] != ia[W-1]);
    e.stamp = 0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(
    input logic [W-1:0] ia,
    input logic [W-1:0] ib,
    input logic         icin,
    input logic         isub
  );
    exp_t e;
    a = ia;
    b = ib;
    cin = icin;
    sub = isub;
    start = 1'b1;
    tick();
    start = 1'b0;
    e = model(ia, ib, icin, isub);
    e.stamp = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (!done && n < 3 * W) begin
      chk({tag, "_busy"}, busy, 1);
      tick();
      n++;
    end
    if (!done) begin
      chk({tag, "_timeout"}, done, 1);
      return;
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, done, 0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_lat"}, cyc - e.stamp, W);
    chk({tag, "_s"}, s, e.s);
    chk({tag, "_c"}, c, e.c);
    chk({tag, "_ovf"}, ovf, e.ovf);
    chk({tag, "_busy_done"}, busy, 0);
  endtask

  initial begin
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_s", s, 0);
    chk("rst_c", c, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    issue(8'd3, 8'd5, 1'b0, 1'b0);
    wait_done("add35");
    chk("add35_s_const", s, 8'd8);
    tick();
    chk("done_pulse", done, 0);

    issue(8'd255, 8'd1, 1'b0, 1'b0);
    wait_done("wrap");
    chk("wrap_c_const", c, 1);
    tick();

    issue(8'd255, 8'd0, 1'b1, 1'b0);
    wait_done("cin");
    tick();

    issue(8'd5, 8'd3, 1'b1, 1'b1);
    wait_done("sub53");
    tick();

    issue(8'd3, 8'd5, 1'b1, 1'b1);
    wait_done("sub35");
    chk("sub35_s_const", s, 8'hFE);
    tick();

    issue(8'd127, 8'd1, 1'b0, 1'b0);
    wait_done("ovf_pos");
    tick();

    issue(8'h80, 8'hFF, 1'b0, 1'b0);
    wait_done("ovf_neg");

    issue(8'd10, 8'd20, 1'b0, 1'b0);
    chk("b2b_hold_s", s, 8'h7F);
    chk("b2b_hold_ovf", ovf, 1);
    wait_done("b2b");
    chk("b2b_s_const", s, 8'd30);
    tick();

    issue(8'h11, 8'h22, 1'b0, 1'b0);
    tick();
    tick();
    a = 8'h55;
    b = 8'h66;
    sub = 1'b1;
    cin = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ign");
    tick();

    a = 8'h40;
    b = 8'h02;
    cin = 1'b0;
    sub = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_s", s, 0);
    chk("mrst_c", c, 0);
    chk("mrst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    issue(8'hA5, 8'h3C, 1'b1, 1'b0);
    wait_done("post_rst");
    tick();
    chk("post_rst_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
